// File: rtl/masked_sram.sv
// Dual-port lane-masked synchronous SRAM with a power-up clear engine and selectable read latency.
// Optional collision statistics port enabled by defining MASKED_SRAM_STATS_EN.
module masked_sram #(
    parameter int LANES        = 4,
    parameter int LANE_WIDTH   = 8,
    parameter int A_WIDTH      = 8,
    parameter int TOTAL_WORDS  = 0,
    parameter int READ_LATENCY = 1,
    parameter int RDW_NEW_DATA = 0,
    parameter logic [LANES*LANE_WIDTH-1:0] CLEAR_VALUE = {(LANES*LANE_WIDTH){1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          busy,
    input  logic [A_WIDTH-1:0]            addr_a,
    input  logic                          read_en_a,
    input  logic [LANES-1:0]              write_en_a,
    input  logic [LANES*LANE_WIDTH-1:0]   write_a,
    output logic [LANES*LANE_WIDTH-1:0]   read_a,
    output logic                          read_valid_a,
    input  logic [A_WIDTH-1:0]            addr_b,
    input  logic                          read_en_b,
    input  logic [LANES-1:0]              write_en_b,
    input  logic [LANES*LANE_WIDTH-1:0]   write_b,
    output logic [LANES*LANE_WIDTH-1:0]   read_b,
    output logic                          read_valid_b
`ifdef MASKED_SRAM_STATS_EN
    ,
    output logic [15:0]                   collision_count
`endif
);

    localparam int D_WIDTH  = LANES * LANE_WIDTH;
    localparam int NUM_ADDR = (TOTAL_WORDS == 0) ? (1 << A_WIDTH) : TOTAL_WORDS;
    localparam int IDX_W    = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ADDR - 1);
    localparam logic [A_WIDTH:0] NUM_ADDR_W = (A_WIDTH + 1)'(NUM_ADDR);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("masked_sram: READ_LATENCY must be 1 or 2");
    end
    if (TOTAL_WORDS > (1 << A_WIDTH)) begin : g_bad_depth
        $error("masked_sram: TOTAL_WORDS exceeds address space");
    end

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    // Replace the enabled lanes of old_word with the matching lanes of new_word.
    function automatic logic [D_WIDTH-1:0] lane_merge(
        input logic [D_WIDTH-1:0] old_word,
        input logic [D_WIDTH-1:0] new_word,
        input logic [LANES-1:0]   lane_en
    );
        logic [D_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            merged[i*LANE_WIDTH +: LANE_WIDTH] = lane_en[i] ? new_word[i*LANE_WIDTH +: LANE_WIDTH]
                                                            : old_word[i*LANE_WIDTH +: LANE_WIDTH];
        end
        return merged;
    endfunction

    logic [D_WIDTH-1:0] mem [NUM_ADDR];

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   clr_idx_r;
    logic [IDX_W-1:0]   clr_idx_next_s;
    logic               ready_s;
    logic               clr_we_s;

    logic [IDX_W-1:0]   idx_a_s;
    logic [IDX_W-1:0]   idx_b_s;
    logic               in_range_a_s;
    logic               in_range_b_s;
    logic [LANES-1:0]   wr_a_s;
    logic [LANES-1:0]   wr_b_s;
    logic               rd_acc_a_s;
    logic               rd_acc_b_s;
    logic [D_WIDTH-1:0] rd_word_a_s;
    logic [D_WIDTH-1:0] rd_word_b_s;

    // Clear engine state and address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_CLEAR;
            clr_idx_r <= {IDX_W{1'b0}};
            busy      <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            clr_idx_r <= clr_idx_next_s;
            busy      <= (state_next_s == S_CLEAR);
        end
    end

    // Clear engine next-state: sweep every word once, then stay ready until reset.
    always_comb begin
        state_next_s   = state_r;
        clr_idx_next_s = clr_idx_r;
        case (state_r)
            S_CLEAR: begin
                if (clr_idx_r == LAST_IDX) begin
                    state_next_s = S_READY;
                end else begin
                    state_next_s   = S_CLEAR;
                    clr_idx_next_s = clr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            S_READY: begin
                state_next_s = S_READY;
            end
            default: begin
                state_next_s   = S_CLEAR;
                clr_idx_next_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // Port qualification and read-word selection (RDW merge applies to the same port only).
    always_comb begin
        ready_s      = (state_r == S_READY);
        clr_we_s     = (state_r == S_CLEAR);
        idx_a_s      = addr_a[IDX_W-1:0];
        idx_b_s      = addr_b[IDX_W-1:0];
        in_range_a_s = ({1'b0, addr_a} < NUM_ADDR_W);
        in_range_b_s = ({1'b0, addr_b} < NUM_ADDR_W);
        wr_a_s       = (ready_s && in_range_a_s) ? write_en_a : {LANES{1'b0}};
        wr_b_s       = (ready_s && in_range_b_s) ? write_en_b : {LANES{1'b0}};
        rd_acc_a_s   = ready_s && read_en_a;
        rd_acc_b_s   = ready_s && read_en_b;
        rd_word_a_s  = {D_WIDTH{1'b0}};
        rd_word_b_s  = {D_WIDTH{1'b0}};
        if (in_range_a_s) begin
            if (RDW_NEW_DATA != 0) begin
                rd_word_a_s = lane_merge(mem[idx_a_s], write_a, wr_a_s);
            end else begin
                rd_word_a_s = mem[idx_a_s];
            end
        end else begin
            rd_word_a_s = {D_WIDTH{1'b0}};
        end
        if (in_range_b_s) begin
            if (RDW_NEW_DATA != 0) begin
                rd_word_b_s = lane_merge(mem[idx_b_s], write_b, wr_b_s);
            end else begin
                rd_word_b_s = mem[idx_b_s];
            end
        end else begin
            rd_word_b_s = {D_WIDTH{1'b0}};
        end
    end

    // Array writes; port B lanes are applied first so port A overrides on shared lanes.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem[clr_idx_r] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_b_s[i]) begin
                    mem[idx_b_s][i*LANE_WIDTH +: LANE_WIDTH] <= write_b[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
            for (int i = 0; i < LANES; i++) begin
                if (wr_a_s[i]) begin
                    mem[idx_a_s][i*LANE_WIDTH +: LANE_WIDTH] <= write_a[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        // Single-stage read: data lands on the outputs the cycle after the request.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                read_a       <= {D_WIDTH{1'b0}};
                read_b       <= {D_WIDTH{1'b0}};
                read_valid_a <= 1'b0;
                read_valid_b <= 1'b0;
            end else begin
                read_valid_a <= rd_acc_a_s;
                read_valid_b <= rd_acc_b_s;
                if (rd_acc_a_s) begin
                    read_a <= rd_word_a_s;
                end
                if (rd_acc_b_s) begin
                    read_b <= rd_word_b_s;
                end
            end
        end
    end else begin : g_lat2
        logic [D_WIDTH-1:0] s1_data_a_r;
        logic [D_WIDTH-1:0] s1_data_b_r;
        logic               s1_valid_a_r;
        logic               s1_valid_b_r;

        // Two-stage read: array register followed by an output register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_data_a_r  <= {D_WIDTH{1'b0}};
                s1_data_b_r  <= {D_WIDTH{1'b0}};
                s1_valid_a_r <= 1'b0;
                s1_valid_b_r <= 1'b0;
                read_a       <= {D_WIDTH{1'b0}};
                read_b       <= {D_WIDTH{1'b0}};
                read_valid_a <= 1'b0;
                read_valid_b <= 1'b0;
            end else begin
                s1_valid_a_r <= rd_acc_a_s;
                s1_valid_b_r <= rd_acc_b_s;
                if (rd_acc_a_s) begin
                    s1_data_a_r <= rd_word_a_s;
                end
                if (rd_acc_b_s) begin
                    s1_data_b_r <= rd_word_b_s;
                end
                read_valid_a <= s1_valid_a_r;
                read_valid_b <= s1_valid_b_r;
                if (s1_valid_a_r) begin
                    read_a <= s1_data_a_r;
                end
                if (s1_valid_b_r) begin
                    read_b <= s1_data_b_r;
                end
            end
        end
    end

`ifdef MASKED_SRAM_STATS_EN
    logic coll_s;

    // Same in-range address written by both ports with at least one shared lane.
    always_comb begin
        coll_s = (addr_a == addr_b) && (|(wr_a_s & wr_b_s));
    end

    // Saturating collision counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision_count <= 16'h0000;
        end else if (coll_s && (collision_count != 16'hFFFF)) begin
            collision_count <= collision_count + 16'h0001;
        end else begin
            collision_count <= collision_count;
        end
    end
`endif

endmodule

// File: tb/tb_masked_sram.sv
// Directed self-checking bench for masked_sram: one latency-1/RDW-new instance and one
// latency-2/RDW-old instance share the same stimulus (16 words, clear value A5A5A5A5).
module tb_masked_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr_a;
    logic        read_en_a;
    logic [3:0]  write_en_a;
    logic [31:0] write_a;
    logic [7:0]  addr_b;
    logic        read_en_b;
    logic [3:0]  write_en_b;
    logic [31:0] write_b;

    logic        busy1, rva1, rvb1, busy2, rva2, rvb2;
    logic [31:0] ra1, rb1, ra2, rb2;
`ifdef MASKED_SRAM_STATS_EN
    logic [15:0] cc1, cc2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    masked_sram #(
        .LANES(4), .LANE_WIDTH(8), .A_WIDTH(8), .TOTAL_WORDS(16),
        .READ_LATENCY(1), .RDW_NEW_DATA(1), .CLEAR_VALUE(32'hA5A5A5A5)
    ) u1 (
        .clk(clk), .rst(rst), .busy(busy1),
        .addr_a(addr_a), .read_en_a(read_en_a), .write_en_a(write_en_a), .write_a(write_a),
        .read_a(ra1), .read_valid_a(rva1),
        .addr_b(addr_b), .read_en_b(read_en_b), .write_en_b(write_en_b), .write_b(write_b),
        .read_b(rb1), .read_valid_b(rvb1)
`ifdef MASKED_SRAM_STATS_EN
        , .collision_count(cc1)
`endif
    );

    masked_sram #(
        .LANES(4), .LANE_WIDTH(8), .A_WIDTH(8), .TOTAL_WORDS(16),
        .READ_LATENCY(2), .RDW_NEW_DATA(0), .CLEAR_VALUE(32'hA5A5A5A5)
    ) u2 (
        .clk(clk), .rst(rst), .busy(busy2),
        .addr_a(addr_a), .read_en_a(read_en_a), .write_en_a(write_en_a), .write_a(write_a),
        .read_a(ra2), .read_valid_a(rva2),
        .addr_b(addr_b), .read_en_b(read_en_b), .write_en_b(write_en_b), .write_b(write_b),
        .read_b(rb2), .read_valid_b(rvb2)
`ifdef MASKED_SRAM_STATS_EN
        , .collision_count(cc2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        read_en_a  = 1'b0;
        read_en_b  = 1'b0;
        write_en_a = 4'b0000;
        write_en_b = 4'b0000;
    endtask

    initial begin
        int n;
        int rv_seen;
        logic [31:0] pat;

        rst = 1'b1;
        addr_a = 8'd0; addr_b = 8'd0;
        write_a = 32'h0; write_b = 32'h0;
        idle_ports();
        repeat (3) step();

        check("reset_busy1", {31'd0, busy1}, 32'd1);
        check("reset_busy2", {31'd0, busy2}, 32'd1);
        check("reset_rva1", {31'd0, rva1}, 32'd0);
        check("reset_rvb2", {31'd0, rvb2}, 32'd0);
        check("reset_ra1", ra1, 32'h0);
        check("reset_rb2", rb2, 32'h0);
`ifdef MASKED_SRAM_STATS_EN
        check("reset_cc1", {16'd0, cc1}, 32'd0);
`endif

        // Start a clear, interrupt it at cycle 7 with reset.
        rst = 1'b0;
        repeat (7) step();
        check("mid_clear_busy", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_clear_busy1", {31'd0, busy1}, 32'd1);
        check("rst_mid_clear_busy2", {31'd0, busy2}, 32'd1);
        step();
        rst = 1'b0;

        // Count busy cycles while hammering both ports with requests.
        n = 0;
        rv_seen = 0;
        read_en_a = 1'b1; read_en_b = 1'b1;
        write_en_a = 4'b1111; write_a = 32'hDEADBEEF;
        while (busy1 && n < 40) begin
            addr_a = 8'(n);
            addr_b = 8'(n);
            step();
            n++;
            if (rva1 || rvb1 || rva2 || rvb2) rv_seen++;
        end
        idle_ports();
        check("clear_cycles", 32'(n), 32'd16);
        check("no_valid_while_busy", 32'(rv_seen), 32'd0);
        check("busy2_done", {31'd0, busy2}, 32'd0);

        // Back-to-back reads of the cleared array on port A.
        for (int i = 0; i < 16; i++) begin
            addr_a = 8'(i);
            read_en_a = 1'b1;
            step();
            check("clr_rva1", {31'd0, rva1}, 32'd1);
            check("clr_ra1", ra1, 32'hA5A5A5A5);
            if (i > 0) begin
                check("clr_rva2", {31'd0, rva2}, 32'd1);
                check("clr_ra2", ra2, 32'hA5A5A5A5);
            end
        end
        read_en_a = 1'b0;
        step();
        check("clr_tail_rva1", {31'd0, rva1}, 32'd0);
        check("clr_tail_rva2", {31'd0, rva2}, 32'd1);
        check("clr_tail_ra2", ra2, 32'hA5A5A5A5);
        step();
        check("clr_end_rva2", {31'd0, rva2}, 32'd0);

        // Lane-masked write.
        addr_a = 8'd3; write_a = 32'h11223344; write_en_a = 4'b0101;
        step();
        write_en_a = 4'b0000; read_en_a = 1'b1;
        step();
        read_en_a = 1'b0;
        check("mask_rva1", {31'd0, rva1}, 32'd1);
        check("mask_ra1", ra1, 32'hA522A544);
        step();
        check("mask_rva2", {31'd0, rva2}, 32'd1);
        check("mask_ra2", ra2, 32'hA522A544);

        // Fill words 0..2 then read them back-to-back on port B.
        for (int i = 0; i < 3; i++) begin
            pat = 32'h01010101 * 32'(i + 1);
            addr_a = 8'(i); write_a = pat; write_en_a = 4'b1111;
            step();
        end
        write_en_a = 4'b0000;
        addr_b = 8'd0; read_en_b = 1'b1;
        step();
        check("b2b_rvb1_0", {31'd0, rvb1}, 32'd1);
        check("b2b_rb1_0", rb1, 32'h01010101);
        check("b2b_rvb2_0", {31'd0, rvb2}, 32'd0);
        addr_b = 8'd1;
        step();
        check("b2b_rb1_1", rb1, 32'h02020202);
        check("b2b_rvb2_1", {31'd0, rvb2}, 32'd1);
        check("b2b_rb2_1", rb2, 32'h01010101);
        addr_b = 8'd2;
        step();
        check("b2b_rb1_2", rb1, 32'h03030303);
        check("b2b_rb2_2", rb2, 32'h02020202);
        read_en_b = 1'b0;
        step();
        check("b2b_rvb1_3", {31'd0, rvb1}, 32'd0);
        check("b2b_rvb2_3", {31'd0, rvb2}, 32'd1);
        check("b2b_rb2_3", rb2, 32'h03030303);
        step();
        check("b2b_rvb2_4", {31'd0, rvb2}, 32'd0);
        check("b2b_rb2_hold", rb2, 32'h03030303);

        // Out-of-range write is dropped, out-of-range read returns zero.
        addr_a = 8'd20; write_a = 32'hFFFFFFFF; write_en_a = 4'b1111;
        step();
        write_en_a = 4'b0000; read_en_a = 1'b1;
        step();
        check("oor_rva1", {31'd0, rva1}, 32'd1);
        check("oor_ra1", ra1, 32'h0);
        addr_a = 8'd4;
        step();
        read_en_a = 1'b0;
        check("oor_alias_ra1", ra1, 32'hA5A5A5A5);
        check("oor_ra2", ra2, 32'h0);
        step();
        check("oor_alias_ra2", ra2, 32'hA5A5A5A5);

        // Same-port read-during-write on word 5.
        addr_a = 8'd5; write_a = 32'h0; write_en_a = 4'b1111;
        step();
        read_en_a = 1'b1; write_a = 32'hFFFFFFFF; write_en_a = 4'b0011;
        step();
        idle_ports();
        check("rdw_new_ra1", ra1, 32'h0000FFFF);
        step();
        check("rdw_old_rva2", {31'd0, rva2}, 32'd1);
        check("rdw_old_ra2", ra2, 32'h00000000);
        read_en_a = 1'b1;
        step();
        read_en_a = 1'b0;
        check("rdw_after_ra1", ra1, 32'h0000FFFF);
        step();
        check("rdw_after_ra2", ra2, 32'h0000FFFF);

        // Cross-port read of a word being written by the other port returns the old word.
        addr_a = 8'd7; write_a = 32'h12345678; write_en_a = 4'b1111;
        addr_b = 8'd7; read_en_b = 1'b1;
        step();
        idle_ports();
        check("xport_rb1", rb1, 32'hA5A5A5A5);
        step();
        check("xport_rb2", rb2, 32'hA5A5A5A5);

        // Cross-port write collision on word 6.
        addr_a = 8'd6; write_a = 32'h0; write_en_a = 4'b1111;
        step();
        write_a = 32'h11111111; write_en_a = 4'b0011;
        addr_b = 8'd6; write_b = 32'h22222222; write_en_b = 4'b0110;
        step();
        idle_ports();
        read_en_a = 1'b1;
        step();
        read_en_a = 1'b0;
        check("coll_ra1", ra1, 32'h00221111);
        step();
        check("coll_ra2", ra2, 32'h00221111);
`ifdef MASKED_SRAM_STATS_EN
        check("coll_cc1", {16'd0, cc1}, 32'd1);
        check("coll_cc2", {16'd0, cc2}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/masked_sram.md
Name: masked_sram

Overview:
- Generalised dual-port synchronous SRAM for Cyclone IV block RAM.
- Data word is LANES x LANE_WIDTH bits, with a per-lane write mask on each port.
- Read latency is selectable; each read produces a read-valid strobe.
- Read-during-write behaviour is a parameter. A built-in clear engine fills the array with CLEAR_VALUE after reset.
- Shared frame/tile/scratch memory for the video and CPU subsystems, replacing the fixed-width unmasked RAM.

Parameters:
- LANES, 4, number of independently writable lanes per word.
- LANE_WIDTH, 8, bits per lane; D_WIDTH = LANES*LANE_WIDTH.
- A_WIDTH, 8, address width.
- TOTAL_WORDS, 0, depth; 0 means 2**A_WIDTH; must be <= 2**A_WIDTH.
- READ_LATENCY, 1, 1 = registered array output; 2 = extra output register; other values are illegal (elaboration error).
- RDW_NEW_DATA, 0, same-port read-during-write: 0 returns old word, 1 returns merged new word.
- CLEAR_VALUE, 0, D_WIDTH-bit value written to every word by the clear engine.

Ports:
- clk  in  1  single clock for everything.
- rst  in  1  asynchronous, active-high reset.
- busy  out  1  high while the clear engine runs; ports are ignored while high.
- addr_a  in  A_WIDTH  port A address.
- read_en_a  in  1  port A read request.
- write_en_a  in  LANES  port A per-lane write enables.
- write_a  in  D_WIDTH  port A write data; lane i = bits [i*LANE_WIDTH +: LANE_WIDTH].
- read_a  out  D_WIDTH  port A read data.
- read_valid_a  out  1  read_a is valid this cycle.
- addr_b, read_en_b, write_en_b, write_b, read_b, read_valid_b: identical for port B.

Behaviour:
Reset (rst high, asynchronous):
- busy=1, read_valid_a/b=0, read_a/b=0.
- Clear counter=0, FSM in CLEAR, valid pipelines flushed.
- Array contents are not required to reset.

Clear FSM:
- CLEAR: each cycle with rst low, write CLEAR_VALUE (all lanes) to address counter, then increment.
- On writing word NUM_ADDR-1 -> READY; busy falls the cycle after that write.
- Clear takes exactly NUM_ADDR cycles after rst deassert.
- READY: stays until the next rst. A reset mid-clear restarts the clear from address 0.
- While busy: all port requests are ignored and read_valid stays 0.

Write:
- In READY, on the rising edge, each lane i with write_en_x[i]=1 updates that lane of word addr_x.
- Other lanes are unchanged.

Read:
- A read accepted at edge N (read_en_x=1, READY) gives read_x with read_valid_x=1 after edge N+READ_LATENCY-1, i.e. visible for exactly one cycle:
  - latency 1: the cycle after request.
  - latency 2: two cycles after request.
- Back-to-back reads are fully pipelined, one per cycle.
- read_x holds its last value when no valid data arrives; it is never zeroed after reset.

Same-port read and write to the same address in one cycle:
- RDW_NEW_DATA=0: returns the pre-write word.
- RDW_NEW_DATA=1: returns the word with the enabled lanes replaced by write_x.

Cross-port collision (both ports write the same address):
- Port A wins on overlapping enabled lanes.
- Non-overlapping lanes from both ports are written.
- A read on one port of an address written by the other port in the same cycle returns the old word.

Out of range (addr >= NUM_ADDR):
- Writes are dropped.
- Reads complete normally with read_valid, data = 0.

Optional Feature:
MASKED_SRAM_STATS_EN
- Defined: adds output port collision_count (16 bits).
  - Increments once per READY cycle where both ports write the same in-range address with at least one overlapping lane.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Clear: TOTAL_WORDS=16, CLEAR_VALUE=32'hA5A5A5A5. Release rst -> busy high exactly 16 cycles. Then reads of addresses 0..15 return A5A5A5A5 with read_valid one cycle later (latency 1).
- Masking: write addr 3, data 32'h11223344, write_en_a=4'b0101, after clear -> read returns 32'hA522A544.
- Latency 2: reads of addresses 0,1,2 in consecutive cycles -> read_valid_b high on the 2nd, 3rd and 4th cycles after the first request, data in order.
- RDW: RDW_NEW_DATA=1, word=32'h0, same-cycle read+write 32'hFFFFFFFF with mask 4'b0011 on port A -> read_a=32'h0000FFFF. With RDW_NEW_DATA=0 -> 32'h0.
- Collision: A writes 32'h11111111 mask 4'b0011, B writes 32'h22222222 mask 4'b0110, same address -> word=32'h00221111 (from 0). With stats enabled, collision_count=1.
- Reset mid-clear: assert rst at clear cycle 7 -> busy stays high. After deassert, exactly NUM_ADDR more cycles of busy; port requests during busy give no read_valid.
